// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes, FSM state encoding,
// oversample factor and the parity helper used by both directions.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int OS = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_t;

    // Narrow words are zero-extended by the caller; extra zeros do not change the XOR.
    function automatic logic parity_bit(input logic [8:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one-cycle os_tick every DIV sys_clk cycles,
// where DIV is CLK_HZ / (BAUD*OS) rounded to nearest.
module uart_baud_tick #(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 115200,
    parameter int OS     = 16
) (
    input  logic sys_clk,
    input  logic rst,
    output logic os_tick
);

    localparam int DIV = (CLK_HZ + (BAUD * OS) / 2) / (BAUD * OS);
    localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);

    if (DIV < 2) begin : g_div_check
        $error("uart_baud_tick: clock too slow for requested baud rate");
    end

    logic [CW-1:0] cnt;

    assign os_tick = (cnt == CW'(DIV - 1));

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (os_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART with configurable frame format; TX and RX FSMs share one
// oversample tick, RX samples mid-bit and rejects start-bit glitches.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 tx_en,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 uart_tx,
    output logic                 uart_tx_busy,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err
);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
        $error("uart_transceiver: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_parity_check
        $error("uart_transceiver: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_transceiver: STOP_BITS must be 1 or 2");
    end

    localparam logic [4:0] BIT_LAST  = 5'(OS - 1);
    localparam logic [4:0] HALF_LAST = 5'(OS / 2 - 1);
    localparam logic [4:0] STOP_LAST = 5'(OS * STOP_BITS - 1);
    localparam logic [3:0] WORD_LAST = 4'(DATA_BITS - 1);

    logic os_tick;

    uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OS(OS)) u_baud (
        .sys_clk (sys_clk),
        .rst     (rst),
        .os_tick (os_tick)
    );

    uart_state_t          tx_state, tx_state_n;
    logic [4:0]           tx_cnt, tx_cnt_n;
    logic [3:0]           tx_idx, tx_idx_n;
    logic [DATA_BITS-1:0] tx_word, tx_word_n;
    logic                 tx_par, tx_par_n, tx_line, tx_line_n, tx_busy, tx_busy_n;

    assign uart_tx      = tx_line;
    assign uart_tx_busy = tx_busy;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_word  <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_idx   <= tx_idx_n;
            tx_word  <= tx_word_n;
            tx_par   <= tx_par_n;
            tx_line  <= tx_line_n;
            tx_busy  <= tx_busy_n;
        end
    end

    // Busy in IDLE means a word is latched and waits for the next tick to start.
    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_idx_n   = tx_idx;
        tx_word_n  = tx_word;
        tx_par_n   = tx_par;
        tx_line_n  = tx_line;
        tx_busy_n  = tx_busy;
        case (tx_state)
            ST_IDLE: begin
                tx_line_n = 1'b1;
                if (!tx_busy && tx_en) begin
                    tx_busy_n = 1'b1;
                    tx_word_n = tx_data;
                    tx_par_n  = parity_bit(9'(tx_data), PARITY);
                end else if (tx_busy && os_tick) begin
                    tx_state_n = ST_START;
                    tx_line_n  = 1'b0;
                    tx_cnt_n   = '0;
                end
            end
            ST_START: if (os_tick) begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = ST_DATA;
                    tx_cnt_n   = '0;
                    tx_idx_n   = '0;
                    tx_line_n  = tx_word[0];
                end
            end
            ST_DATA: if (os_tick) begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_cnt_n = '0;
                    if (tx_idx == WORD_LAST) begin
                        tx_state_n = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                        tx_line_n  = (PARITY == PARITY_NONE) ? 1'b1 : tx_par;
                    end else begin
                        tx_idx_n  = tx_idx + 1'b1;
                        tx_word_n = tx_word >> 1;
                        tx_line_n = tx_word[1];
                    end
                end
            end
            ST_PARITY: if (os_tick) begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == BIT_LAST) begin
                    tx_state_n = ST_STOP;
                    tx_cnt_n   = '0;
                    tx_line_n  = 1'b1;
                end
            end
            ST_STOP: if (os_tick) begin
                tx_cnt_n = tx_cnt + 1'b1;
                if (tx_cnt == STOP_LAST) begin
                    tx_state_n = ST_IDLE;
                    tx_cnt_n   = '0;
                    tx_busy_n  = 1'b0;
                end
            end
            default: tx_state_n = ST_IDLE;
        endcase
    end

    logic                 rx_s1, rx_s2, rx_prev;
    logic                 rx_line;
    uart_state_t          rx_state, rx_state_n;
    logic [4:0]           rx_cnt, rx_cnt_n;
    logic [3:0]           rx_idx, rx_idx_n;
    logic [DATA_BITS-1:0] rx_word, rx_word_n, rx_data_n;
    logic                 rx_perr, rx_perr_n;
    logic                 rx_valid_n, rx_parity_err_n, rx_frame_err_n;

    assign rx_line = rx_s2;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            rx_s1         <= 1'b1;
            rx_s2         <= 1'b1;
            rx_prev       <= 1'b1;
            rx_state      <= ST_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_word       <= '0;
            rx_perr       <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_s1         <= uart_rx;
            rx_s2         <= rx_s1;
            rx_prev       <= rx_line;
            rx_state      <= rx_state_n;
            rx_cnt        <= rx_cnt_n;
            rx_idx        <= rx_idx_n;
            rx_word       <= rx_word_n;
            rx_perr       <= rx_perr_n;
            rx_data       <= rx_data_n;
            rx_valid      <= rx_valid_n;
            rx_parity_err <= rx_parity_err_n;
            rx_frame_err  <= rx_frame_err_n;
        end
    end

    // START counts half a bit to land mid-bit; every later sample is a full bit apart.
    always_comb begin
        rx_state_n      = rx_state;
        rx_cnt_n        = rx_cnt;
        rx_idx_n        = rx_idx;
        rx_word_n       = rx_word;
        rx_perr_n       = rx_perr;
        rx_data_n       = rx_data;
        rx_valid_n      = 1'b0;
        rx_parity_err_n = rx_parity_err;
        rx_frame_err_n  = rx_frame_err;
        case (rx_state)
            ST_IDLE: if (rx_prev && !rx_line) begin
                rx_state_n = ST_START;
                rx_cnt_n   = '0;
            end
            ST_START: if (os_tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_n   = '0;
                    rx_idx_n   = '0;
                    rx_perr_n  = 1'b0;
                    rx_state_n = rx_line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: if (os_tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n  = '0;
                    rx_word_n = {rx_line, rx_word[DATA_BITS-1:1]};
                    rx_idx_n  = rx_idx + 1'b1;
                    if (rx_idx == WORD_LAST) begin
                        rx_state_n = (PARITY == PARITY_NONE) ? ST_STOP : ST_PARITY;
                    end
                end
            end
            ST_PARITY: if (os_tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n   = '0;
                    rx_perr_n  = (rx_line != parity_bit(9'(rx_word), PARITY));
                    rx_state_n = ST_STOP;
                end
            end
            ST_STOP: if (os_tick) begin
                rx_cnt_n = rx_cnt + 1'b1;
                if (rx_cnt == BIT_LAST) begin
                    rx_cnt_n        = '0;
                    rx_valid_n      = 1'b1;
                    rx_data_n       = rx_word;
                    rx_parity_err_n = rx_perr;
                    rx_frame_err_n  = !rx_line;
                    rx_state_n      = rx_line ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: if (rx_line) begin
                rx_state_n = ST_IDLE;
            end
            default: rx_state_n = ST_IDLE;
        endcase
    end

endmodule
